// File: rtl/dual_decode_dispatch.sv
// Two-slot decode dispatch gate: serializes exclusive ops, allocates itags, and
// steers micro-ops ping-pong into two decode queues. Define DECODE_ASSERT_EN for simulation checks.
module dual_decode_dispatch #(
    parameter int PAYLOAD_W = 96,
    parameter int DEPTH     = 16,
    parameter int ITAG_W    = 8
) (
    input  logic                 clk_i,
    input  logic                 arst_i,
    input  logic                 flush_i,
    input  logic [1:0]           in_valid_i,
    input  logic [6:0]           in_opcode0_i,
    input  logic [6:0]           in_opcode1_i,
    input  logic [PAYLOAD_W-1:0] in_payload0_i,
    input  logic [PAYLOAD_W-1:0] in_payload1_i,
    output logic [1:0]           in_ready_o,
    input  logic [1:0]           retire_cnt_i,
    output logic                 q0_wr_o,
    output logic                 q1_wr_o,
    output logic [PAYLOAD_W-1:0] q0_data_o,
    output logic [PAYLOAD_W-1:0] q1_data_o,
    output logic [ITAG_W-1:0]    q0_itag_o,
    output logic [ITAG_W-1:0]    q1_itag_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic                 excl_flag_o
);
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam logic [6:0] OP_AMO     = 7'b0101111;
    localparam logic [6:0] OP_SYSTEM  = 7'b1110011;
    localparam logic [6:0] OP_MISCMEM = 7'b0001111;

    logic [6:0]        opcode [2];
    logic [1:0]        excl;
    logic [1:0]        ready;
    logic [1:0]        n_acc;
    logic [ITAG_W-1:0] itag0;
    logic [ITAG_W-1:0] itag1;

    logic              excl_flag_q, excl_flag_d;
    logic              ptr_q, ptr_d;
    logic [ITAG_W-1:0] itag_q, itag_d;
    logic [OCC_W-1:0]  occ_q, occ_d;

    assign opcode[0] = in_opcode0_i;
    assign opcode[1] = in_opcode1_i;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_excl
            assign excl[gi] = in_valid_i[gi] &
                              ((opcode[gi] == OP_AMO) |
                               (opcode[gi] == OP_SYSTEM) |
                               (opcode[gi] == OP_MISCMEM));
        end
    endgenerate

    // Full means fewer than two free entries, so a pair can always be absorbed when not full.
    assign full_o      = occ_q > OCC_W'(DEPTH - 2);
    assign empty_o     = occ_q == '0;
    assign excl_flag_o = excl_flag_q;

    always_comb begin
        ready[0] = in_valid_i[0] & ~full_o &
                   ((excl[0] | excl_flag_q) ? empty_o : 1'b1);
        ready[1] = in_valid_i[1] & ~full_o & ~excl[0] & ~excl[1] & ~excl_flag_q;
        n_acc    = {1'b0, ready[0]} + {1'b0, ready[1]};
    end

    assign in_ready_o = ready;
    assign itag0      = itag_q;
    assign itag1      = itag_q + ITAG_W'(1);

    // Slot 0 always lands in queue[ptr]; slot 1 takes the other queue.
    always_comb begin
        q0_wr_o   = ptr_q ? ready[1] : ready[0];
        q1_wr_o   = ptr_q ? ready[0] : ready[1];
        q0_data_o = ptr_q ? in_payload1_i : in_payload0_i;
        q1_data_o = ptr_q ? in_payload0_i : in_payload1_i;
        q0_itag_o = ptr_q ? itag1 : itag0;
        q1_itag_o = ptr_q ? itag0 : itag1;
    end

    always_comb begin
        excl_flag_d = ready[0] ? excl[0] : excl_flag_q;
        ptr_d       = ptr_q ^ (ready[0] & ~ready[1]);
        itag_d      = itag_q + ITAG_W'(n_acc);
        occ_d       = occ_q + OCC_W'(n_acc) - OCC_W'(retire_cnt_i);
        if (flush_i) begin
            excl_flag_d = 1'b0;
            ptr_d       = 1'b0;
            itag_d      = '0;
            occ_d       = '0;
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            excl_flag_q <= 1'b0;
            ptr_q       <= 1'b0;
            itag_q      <= '0;
            occ_q       <= '0;
        end else begin
            excl_flag_q <= excl_flag_d;
            ptr_q       <= ptr_d;
            itag_q      <= itag_d;
            occ_q       <= occ_d;
        end
    end

`ifdef DECODE_ASSERT_EN
    always @(posedge clk_i) begin
        if (!arst_i) begin
            if ($isunknown(in_valid_i) || $isunknown(in_ready_o))
                $error("dual_decode_dispatch: X/Z on in_valid_i or in_ready_o");
            if (in_ready_o[1] && excl[1])
                $error("dual_decode_dispatch: exclusive op accepted from slot 1");
            if (in_valid_i[1] && !in_valid_i[0])
                $error("dual_decode_dispatch: slot 1 valid without slot 0");
            if (OCC_W'(retire_cnt_i) > occ_q)
                $error("dual_decode_dispatch: retire count exceeds occupancy");
        end
    end
`else
`endif

endmodule

// File: tb/tb_dual_decode_dispatch.sv
// Directed bench for dual_decode_dispatch: steering, itags, exclusive serialization,
// occupancy limits, flush and asynchronous reset.
module tb_dual_decode_dispatch;
    localparam int PW = 96;
    localparam int IW = 8;
    localparam logic [6:0] ADD = 7'b0110011;
    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SYS = 7'b1110011;
    localparam logic [6:0] AMO = 7'b0101111;

    logic          clk_i = 1'b0;
    logic          arst_i = 1'b1;
    logic          flush_i = 1'b0;
    logic [1:0]    in_valid_i = '0;
    logic [6:0]    in_opcode0_i = ADD;
    logic [6:0]    in_opcode1_i = ADD;
    logic [PW-1:0] in_payload0_i = '0;
    logic [PW-1:0] in_payload1_i = '0;
    logic [1:0]    in_ready_o;
    logic [1:0]    retire_cnt_i = '0;
    logic          q0_wr_o, q1_wr_o;
    logic [PW-1:0] q0_data_o, q1_data_o;
    logic [IW-1:0] q0_itag_o, q1_itag_o;
    logic          full_o, empty_o, excl_flag_o;

    int errors = 0;
    int checks = 0;

    dual_decode_dispatch #(.PAYLOAD_W(PW), .DEPTH(16), .ITAG_W(IW)) dut (
        .clk_i(clk_i), .arst_i(arst_i), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_opcode0_i(in_opcode0_i), .in_opcode1_i(in_opcode1_i),
        .in_payload0_i(in_payload0_i), .in_payload1_i(in_payload1_i),
        .in_ready_o(in_ready_o), .retire_cnt_i(retire_cnt_i),
        .q0_wr_o(q0_wr_o), .q1_wr_o(q1_wr_o), .q0_data_o(q0_data_o), .q1_data_o(q1_data_o),
        .q0_itag_o(q0_itag_o), .q1_itag_o(q1_itag_o),
        .full_o(full_o), .empty_o(empty_o), .excl_flag_o(excl_flag_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [6:0] op0, input logic [6:0] op1,
                         input logic [PW-1:0] p0, input logic [PW-1:0] p1, input logic [1:0] ret);
        in_valid_i    = v;
        in_opcode0_i  = op0;
        in_opcode1_i  = op1;
        in_payload0_i = p0;
        in_payload1_i = p1;
        retire_cnt_i  = ret;
        #1;
    endtask

    task automatic cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_strobes(input string tag, input logic [1:0] rdy, input logic w0, input logic w1);
        chk({tag, ".ready"}, PW'(in_ready_o), PW'(rdy));
        chk({tag, ".q0_wr"}, PW'(q0_wr_o), PW'(w0));
        chk({tag, ".q1_wr"}, PW'(q1_wr_o), PW'(w1));
    endtask

    initial begin
        #2;
        chk("rst.full", PW'(full_o), PW'(0));
        chk("rst.empty", PW'(empty_o), PW'(1));
        chk("rst.excl", PW'(excl_flag_o), PW'(0));
        chk_strobes("rst", 2'b00, 1'b0, 1'b0);
        cycle();
        arst_i = 1'b0;

        // Pair ADD/LW from reset: q0 <- slot0/itag0, q1 <- slot1/itag1
        drive(2'b11, ADD, LW, 'hA0, 'hA1, 2'd0);
        chk_strobes("pair0", 2'b11, 1'b1, 1'b1);
        chk("pair0.q0_data", q0_data_o, 'hA0);
        chk("pair0.q0_itag", PW'(q0_itag_o), PW'(0));
        chk("pair0.q1_data", q1_data_o, 'hA1);
        chk("pair0.q1_itag", PW'(q1_itag_o), PW'(1));
        cycle();
        drive(2'b00, ADD, ADD, '0, '0, 2'd0);
        chk("pair0.empty", PW'(empty_o), PW'(0));

        // Asynchronous reset mid-cycle clears occupancy without a clock edge
        arst_i = 1'b1;
        #1;
        chk("arst.empty", PW'(empty_o), PW'(1));
        arst_i = 1'b0;
        cycle();

        // Single ops A, B, C ping-pong between queues
        drive(2'b01, ADD, ADD, 'hB0, '0, 2'd0);
        chk_strobes("A", 2'b01, 1'b1, 1'b0);
        chk("A.q0_data", q0_data_o, 'hB0);
        chk("A.q0_itag", PW'(q0_itag_o), PW'(0));
        cycle();
        drive(2'b01, LW, ADD, 'hB1, '0, 2'd0);
        chk_strobes("B", 2'b01, 1'b0, 1'b1);
        chk("B.q1_data", q1_data_o, 'hB1);
        chk("B.q1_itag", PW'(q1_itag_o), PW'(1));
        cycle();
        drive(2'b01, ADD, ADD, 'hB2, '0, 2'd0);
        chk_strobes("C", 2'b01, 1'b1, 1'b0);
        chk("C.q0_itag", PW'(q0_itag_o), PW'(2));
        cycle();

        // ptr=1 pair: slot0 -> q1, slot1 -> q0
        drive(2'b11, ADD, LW, 'hC0, 'hC1, 2'd0);
        chk_strobes("ptr1", 2'b11, 1'b1, 1'b1);
        chk("ptr1.q1_data", q1_data_o, 'hC0);
        chk("ptr1.q1_itag", PW'(q1_itag_o), PW'(3));
        chk("ptr1.q0_data", q0_data_o, 'hC1);
        chk("ptr1.q0_itag", PW'(q0_itag_o), PW'(4));
        cycle();

        // SYSTEM waits for empty (occ 5 -> 3 -> 1 -> 0)
        drive(2'b01, SYS, ADD, 'hD0, '0, 2'd2);
        chk_strobes("sys.occ5", 2'b00, 1'b0, 1'b0);
        cycle();
        drive(2'b01, SYS, ADD, 'hD0, '0, 2'd2);
        chk_strobes("sys.occ3", 2'b00, 1'b0, 1'b0);
        cycle();
        drive(2'b01, SYS, ADD, 'hD0, '0, 2'd1);
        chk_strobes("sys.occ1", 2'b00, 1'b0, 1'b0);
        cycle();
        drive(2'b01, SYS, ADD, 'hD0, '0, 2'd0);
        chk_strobes("sys.go", 2'b01, 1'b0, 1'b1);
        chk("sys.q1_data", q1_data_o, 'hD0);
        chk("sys.q1_itag", PW'(q1_itag_o), PW'(5));
        chk("sys.flag_pre", PW'(excl_flag_o), PW'(0));
        cycle();
        chk("sys.flag", PW'(excl_flag_o), PW'(1));

        // ADD+ADD after exclusive: stall until empty, then slot 0 only
        drive(2'b11, ADD, ADD, 'hE0, 'hE1, 2'd1);
        chk_strobes("post.stall", 2'b00, 1'b0, 1'b0);
        cycle();
        drive(2'b11, ADD, ADD, 'hE0, 'hE1, 2'd0);
        chk_strobes("post.go", 2'b01, 1'b1, 1'b0);
        chk("post.q0_data", q0_data_o, 'hE0);
        chk("post.q0_itag", PW'(q0_itag_o), PW'(6));
        cycle();
        chk("post.flag", PW'(excl_flag_o), PW'(0));

        // AMO in slot 1 blocks slot 1 only
        drive(2'b11, ADD, AMO, 'hF0, 'hF1, 2'd0);
        chk_strobes("amo1", 2'b01, 1'b0, 1'b1);
        chk("amo1.q1_itag", PW'(q1_itag_o), PW'(7));
        cycle();

        // Fill occupancy 2 -> 14 with pairs, then one more to 15
        for (int i = 0; i < 6; i++) begin
            drive(2'b11, ADD, LW, PW'(i), PW'(i + 100), 2'd0);
            chk("fill.ready", PW'(in_ready_o), PW'(2'b11));
            chk("fill.full", PW'(full_o), PW'(0));
            cycle();
        end
        drive(2'b01, ADD, ADD, 'h55, '0, 2'd0);
        chk("occ14.full", PW'(full_o), PW'(0));
        chk_strobes("occ14", 2'b01, 1'b1, 1'b0);
        chk("occ14.q0_itag", PW'(q0_itag_o), PW'(20));
        cycle();
        drive(2'b11, ADD, ADD, '0, '0, 2'd0);
        chk("occ15.full", PW'(full_o), PW'(1));
        chk_strobes("occ15", 2'b00, 1'b0, 1'b0);

        // Flush clears everything
        flush_i = 1'b1;
        cycle();
        flush_i = 1'b0;
        drive(2'b00, ADD, ADD, '0, '0, 2'd0);
        chk("flush.empty", PW'(empty_o), PW'(1));
        chk("flush.full", PW'(full_o), PW'(0));

        // Flush wins over a simultaneous accept
        drive(2'b11, ADD, ADD, 'h10, 'h11, 2'd0);
        flush_i = 1'b1;
        chk_strobes("flacc", 2'b11, 1'b1, 1'b1);
        cycle();
        flush_i = 1'b0;
        drive(2'b11, ADD, ADD, 'h20, 'h21, 2'd0);
        chk("flacc.empty", PW'(empty_o), PW'(1));
        chk_strobes("flacc.after", 2'b11, 1'b1, 1'b0 | 1'b1);
        chk("flacc.q0_itag", PW'(q0_itag_o), PW'(0));
        chk("flacc.q1_itag", PW'(q1_itag_o), PW'(1));
        cycle();

        // Flush clears the exclusive flag
        drive(2'b00, ADD, ADD, '0, '0, 2'd2);
        cycle();
        drive(2'b01, SYS, ADD, 'h30, '0, 2'd0);
        chk_strobes("sys2", 2'b01, 1'b1, 1'b0);
        cycle();
        drive(2'b00, ADD, ADD, '0, '0, 2'd0);
        chk("sys2.flag", PW'(excl_flag_o), PW'(1));
        flush_i = 1'b1;
        cycle();
        flush_i = 1'b0;
        #1;
        chk("flush2.flag", PW'(excl_flag_o), PW'(0));
        chk("flush2.empty", PW'(empty_o), PW'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
